spi_sniffer: RTL and testbench
==============================

Name: spi_sniffer

Overview:
- Passive snooper on a SPI-flash bus; decodes READ (0x03) transactions and records the 24-bit byte address.
- Assembles returned bytes into little-endian 32-bit words and strobes them out.
- Provides load/shift helper pulses so a bench or emulated flash can drive spi_so from the tracked address.
- Sits between the external flash bus pins and the system-clock logic that consumes captured firmware words.

Parameters:
- READ_CMD, 8'h03, command byte that starts a tracked read.
- SYNC_STAGES, 2, flip-flop stages synchronising spi_cs/spi_clk/spi_si/spi_so into clk.

Ports:
- clk  in  1  system clock; must be at least 4x the SPI clock rate.
- reset  in  1  asynchronous, active-low reset.
- spi_cs  in  1  flash chip select, active low.
- spi_clk  in  1  SPI clock; mode 0, sampled on its rising edge.
- spi_si  in  1  master-to-flash data (MOSI).
- spi_so  in  1  flash-to-master data (MISO).
- enable  in  1  when low, the decoder is held in IDLE and every output pulse is suppressed.
- data  out  32  last assembled word, byte n at addr_lo==n in bits [8n+7:8n].
- data_stb  out  1  one-clk pulse; data is valid in the same cycle.
- addr_hi  out  22  current word address (byte address [23:2]).
- addr_lo  out  2  current byte lane (byte address [1:0]).
- addr_changed  out  1  one-clk pulse when a new address is latched from the bus.
- load  out  1  one-clk pulse: the emulated flash loads byte {addr_hi,addr_lo} into its shift register.
- shift  out  1  one-clk pulse: the emulated flash shifts its register left by one bit.

Behaviour:
- Reset: all outputs 0, registers cleared, FSM in IDLE.
- Input handling: inputs pass through SYNC_STAGES flops. Rising and falling edges of spi_clk are detected from the synchronised copy, and each edge is acted on exactly once.
- spi_cs high, or enable low: return to IDLE immediately, clear the bit counter, emit no pulses. addr_hi, addr_lo and data hold their values.
- IDLE -> CMD on spi_cs low with enable high.
- CMD: shift spi_si MSB-first on 8 rising edges.
  - Byte == READ_CMD -> ADDR.
  - Any other byte -> IGNORE until spi_cs goes high.
- ADDR: shift 24 bits of spi_si MSB-first.
  - On the 24th rising edge, latch {addr_hi,addr_lo}.
  - addr_changed pulses 1 clk later.
  - load pulses in the same cycle as addr_changed, before the next spi_clk falling edge.
  - Go to DATA.
- DATA: spi_so is captured on rising edges.
  - shift pulses once on each spi_clk falling edge after rising edges 1..7 of the byte. The falling edge after the 8th bit does not shift.
  - On rising edge 8, the byte is written into data lane addr_lo.
  - If addr_lo==3, data_stb pulses 1 clk after that write, with the updated word.
  - The 24-bit address then increments, wrapping from FFFFFF to 000000, and load pulses in the same cycle as the increment.
  - load and shift are never asserted in the same cycle.
- Partial words: lanes not written in the current burst keep their previous contents. Example: a read starting at lane 2 strobes {new b3, new b2, old b1, old b0}.
- spi_cs rising mid-byte: the partial byte is discarded; no data_stb, no address increment.
- Pulse latency from the synchronised spi_clk edge to any output pulse is at most 2 clk.

Optional Feature:
- SPI_SNIFF_FAST_READ_EN defined: command 0x0B is also accepted. After the 24 address bits, 8 dummy clocks are skipped with no pulses. addr_changed and load then fire on the 8th dummy rising edge, and DATA proceeds as for a normal read.
- Undefined: 0x0B is treated as an unknown command (IGNORE).

Decomposition:
- Package spi_sniffer_pkg: state enum (IDLE, CMD, ADDR, DUMMY, DATA, IGNORE), CMD_READ=8'h03, CMD_FAST_READ=8'h0B, bit-count widths.
- Sub-module spi_edge_sync: synchroniser plus rise/fall detection for spi_clk, and synchronised cs/si/so.

Test Plan:
- Reset then enable: cs low, send 03 00 00 00, flash bytes CC BB 00 20.
  - addr_changed once with addr_hi=0, addr_lo=0.
  - load 4 times, shift 28 times.
  - One data_stb with data=32'h2000BBCC; addr_lo wraps to 0 and addr_hi becomes 1.
- Read 03 00 20 02 returning 23 89.
  - addr_hi=0x800, addr_lo=2.
  - data_stb with data[31:16]=16'h8923 and lower half unchanged from the previous word.
- Jump: new cs cycle with 03 01 32 46 returning 02 00 -> addr_changed pulses, addr_hi=0x4C91, data[31:16]=16'h0002.
- Non-read command 9F with further clocks -> no addr_changed, load, shift or data_stb until cs high.
- cs raised after 5 data bits -> no data_stb; address not incremented; next transaction decodes normally.
- enable=0 during a full read at 0x2004 -> no pulses and outputs unchanged. Repeat with enable=1 -> data=32'h000C6477.

Source files
------------

// File: rtl/spi_sniffer_pkg.sv
// Shared types and constants for the SPI-flash read sniffer.
package spi_sniffer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int BIT_CNT_W = 5;
  localparam int ADDR_W    = 24;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the clk domain and flags spi_clk edges.
// All four pins share one chain so data stays aligned with the clock edge that samples it.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_cs,
  input  logic spi_clk,
  input  logic spi_si,
  input  logic spi_so,
  output logic cs,
  output logic si,
  output logic so,
  output logic clk_rise,
  output logic clk_fall
);

  // Bit order: [0]=cs, [1]=clk, [2]=si, [3]=so; cs resets deselected
  logic [3:0] stage_q [SYNC_STAGES];
  logic       clk_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= 4'b0001;
      clk_d <= 1'b0;
    end else begin
      stage_q[0] <= {spi_so, spi_si, spi_clk, spi_cs};
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      clk_d <= stage_q[SYNC_STAGES-1][1];
    end
  end

  assign cs       = stage_q[SYNC_STAGES-1][0];
  assign si       = stage_q[SYNC_STAGES-1][2];
  assign so       = stage_q[SYNC_STAGES-1][3];
  assign clk_rise = stage_q[SYNC_STAGES-1][1] & ~clk_d;
  assign clk_fall = ~stage_q[SYNC_STAGES-1][1] & clk_d;

endmodule

// File: rtl/spi_sniffer.sv
// Passive SPI-flash READ decoder: tracks the byte address and packs returned bytes into words.
// Define SPI_SNIFF_FAST_READ_EN to also decode FAST_READ (0x0B) with its 8 dummy clocks.
module spi_sniffer
  import spi_sniffer_pkg::*;
#(
  parameter logic [7:0] READ_CMD    = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_si,
  input  logic        spi_so,
  input  logic        enable,
  output logic [31:0] data,
  output logic        data_stb,
  output logic [21:0] addr_hi,
  output logic [1:0]  addr_lo,
  output logic        addr_changed,
  output logic        load,
  output logic        shift
);

  logic cs_s, si_s, so_s, rise, fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .spi_cs   (spi_cs),
    .spi_clk  (spi_clk),
    .spi_si   (spi_si),
    .spi_so   (spi_so),
    .cs       (cs_s),
    .si       (si_s),
    .so       (so_s),
    .clk_rise (rise),
    .clk_fall (fall)
  );

  state_t                state, next_state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [22:0]           shreg;
  logic [ADDR_W-1:0]     addr;
  logic                  fast_q;

  logic                  abort, cnt_clr, cnt_inc, sh_en, addr_latch;
  logic                  byte_done, shift_ev, latch_ev, cmd_done, fast_hit;
  logic                  shift_in;
  logic [7:0]            cmd_byte, data_byte;
  logic [ADDR_W-1:0]     addr_word;

  logic                  latch_p1, inc_p1, stb_p1, shift_p1;

  assign abort     = cs_s | ~enable;
  assign shift_in  = (state == DATA) ? so_s : si_s;
  assign cmd_byte  = {shreg[6:0], si_s};
  assign data_byte = {shreg[6:0], so_s};
  assign addr_word = {shreg, si_s};
  assign addr_hi   = addr[23:2];
  assign addr_lo   = addr[1:0];

`ifdef SPI_SNIFF_FAST_READ_EN
  assign fast_hit = (cmd_byte == CMD_FAST_READ);
`else
  assign fast_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    sh_en      = 1'b0;
    addr_latch = 1'b0;
    byte_done  = 1'b0;
    shift_ev   = 1'b0;
    latch_ev   = 1'b0;
    cmd_done   = 1'b0;
    if (abort) begin
      next_state = IDLE;
      cnt_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          next_state = CMD;
          cnt_clr    = 1'b1;
        end
        CMD: if (rise) begin
          sh_en = 1'b1;
          if (bit_cnt == 5'd7) begin
            cnt_clr  = 1'b1;
            cmd_done = 1'b1;
            next_state = (cmd_byte == READ_CMD || fast_hit) ? ADDR : IGNORE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ADDR: if (rise) begin
          sh_en = 1'b1;
          if (bit_cnt == 5'd23) begin
            cnt_clr    = 1'b1;
            addr_latch = 1'b1;
            latch_ev   = ~fast_q;
            next_state = fast_q ? DUMMY : DATA;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DUMMY: if (rise) begin
          if (bit_cnt == 5'd7) begin
            cnt_clr    = 1'b1;
            latch_ev   = 1'b1;
            next_state = DATA;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DATA: begin
          if (rise) begin
            sh_en = 1'b1;
            if (bit_cnt == 5'd7) begin
              cnt_clr   = 1'b1;
              byte_done = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
          // Only the falls inside a byte advance the emulated flash
          if (fall && bit_cnt != '0) shift_ev = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      fast_q       <= 1'b0;
      addr         <= '0;
      data         <= '0;
      latch_p1     <= 1'b0;
      inc_p1       <= 1'b0;
      stb_p1       <= 1'b0;
      shift_p1     <= 1'b0;
      addr_changed <= 1'b0;
      load         <= 1'b0;
      shift        <= 1'b0;
      data_stb     <= 1'b0;
    end else begin
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 5'd1;
      if (sh_en)        shreg <= {shreg[21:0], shift_in};
      if (cmd_done)     fast_q <= fast_hit;

      if (addr_latch)   addr <= addr_word;
      else if (inc_p1)  addr <= addr + 24'd1;
      if (byte_done)    data[{addr_lo, 3'b000} +: 8] <= data_byte;

      // Stage 1: events from the decoded spi_clk edge
      latch_p1 <= latch_ev;
      inc_p1   <= byte_done;
      stb_p1   <= byte_done && (addr_lo == 2'd3);
      shift_p1 <= shift_ev;

      // Stage 2: output pulses, aligned with the address increment
      addr_changed <= latch_p1;
      load         <= latch_p1 | inc_p1;
      shift        <= shift_p1;
      data_stb     <= stb_p1;
    end
  end

endmodule

// File: tb/tb_spi_sniffer.sv
// Scoreboard bench for spi_sniffer: directed SPI transactions, monitor checks every output pulse.
module tb_spi_sniffer;

  localparam int H = 4;  // clk cycles per spi_clk half period

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_si = 1'b0;
  logic        spi_so = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] data;
  logic        data_stb;
  logic [21:0] addr_hi;
  logic [1:0]  addr_lo;
  logic        addr_changed;
  logic        load;
  logic        shift;

  always #5 clk = ~clk;

  spi_sniffer dut (
    .clk          (clk),
    .reset        (reset),
    .spi_cs       (spi_cs),
    .spi_clk      (spi_clk),
    .spi_si       (spi_si),
    .spi_so       (spi_so),
    .enable       (enable),
    .data         (data),
    .data_stb     (data_stb),
    .addr_hi      (addr_hi),
    .addr_lo      (addr_lo),
    .addr_changed (addr_changed),
    .load         (load),
    .shift        (shift)
  );

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int shift_cnt = 0;
  int loads_at_stb = -1;
  logic [31:0] exp_stb_q[$];
  logic [23:0] exp_ac_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got pulse expected none", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse
  always @(negedge clk) begin
    if (reset) begin
      if (data_stb) begin
        if (exp_stb_q.size() == 0) flag("unexpected data_stb");
        else check("data_stb word", data, exp_stb_q.pop_front());
        loads_at_stb = load_cnt;
      end
      if (addr_changed) begin
        if (exp_ac_q.size() == 0) flag("unexpected addr_changed");
        else check("addr_changed addr", {8'h00, addr_hi, addr_lo}, {8'h00, exp_ac_q.pop_front()});
        check("load with addr_changed", {31'h0, load}, 32'h1);
      end
      if (load && shift) flag("load and shift together");
      if (load) load_cnt++;
      if (shift) shift_cnt++;
    end
  end

  task automatic spi_bit(input logic si_b, input logic so_b);
    spi_si = si_b;
    spi_so = so_b;
    repeat (H) @(negedge clk);
    spi_clk = 1'b1;
    repeat (H) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] mosi, input logic [7:0] miso);
    for (int i = 7; i >= 0; i--) spi_bit(mosi[i], miso[i]);
  endtask

  task automatic spi_start();
    spi_cs = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (H) @(negedge clk);
    spi_cs = 1'b1;
    repeat (4 * H) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    spi_byte(cmd, 8'h00);
    spi_byte(a[23:16], 8'h00);
    spi_byte(a[15:8], 8'h00);
    spi_byte(a[7:0], 8'h00);
  endtask

  // resp is returned low byte first
  task automatic read_tx(input logic [7:0] cmd, input logic [23:0] a, input int n,
                         input logic [31:0] resp);
    spi_start();
    send_hdr(cmd, a);
    for (int i = 0; i < n; i++) spi_byte(8'h00, resp[8*i +: 8]);
    spi_end();
  endtask

  int lc, sc;

  initial begin
    repeat (5) @(negedge clk);
    check("reset data", data, 32'h0);
    check("reset addr_hi", {10'h0, addr_hi}, 32'h0);
    check("reset addr_lo", {30'h0, addr_lo}, 32'h0);
    check("reset pulses", {28'h0, data_stb, addr_changed, load, shift}, 32'h0);
    reset = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Aligned read at 0
    exp_ac_q.push_back(24'h000000);
    exp_stb_q.push_back(32'h2000BBCC);
    read_tx(8'h03, 24'h000000, 4, 32'h2000BBCC);
    check("t1 addr_hi", {10'h0, addr_hi}, 32'h1);
    check("t1 addr_lo", {30'h0, addr_lo}, 32'h0);
    check("t1 loads before strobe", 32'(loads_at_stb), 32'd4);
    check("t1 shifts", 32'(shift_cnt), 32'd28);

    // Lane-2 start keeps lower half of previous word
    exp_ac_q.push_back(24'h002002);
    exp_stb_q.push_back(32'h8923BBCC);
    read_tx(8'h03, 24'h002002, 2, 32'h00008923);
    check("t2 addr_hi", {10'h0, addr_hi}, 32'h801);
    check("t2 addr_lo", {30'h0, addr_lo}, 32'h0);

    // Jump to a new address
    exp_ac_q.push_back(24'h013246);
    exp_stb_q.push_back(32'h0002BBCC);
    read_tx(8'h03, 24'h013246, 2, 32'h00000002);
    check("t3 addr_hi", {10'h0, addr_hi}, 32'h4C92);
    check("t3 addr_lo", {30'h0, addr_lo}, 32'h0);

    // Unknown command
    lc = load_cnt; sc = shift_cnt;
    read_tx(8'h9F, 24'h123456, 2, 32'h0000A5A5);
    check("t4 no loads", 32'(load_cnt - lc), 32'd0);
    check("t4 no shifts", 32'(shift_cnt - sc), 32'd0);
    check("t4 addr_hi", {10'h0, addr_hi}, 32'h4C92);

    // cs raised mid-byte
    exp_ac_q.push_back(24'h000010);
    spi_start();
    send_hdr(8'h03, 24'h000010);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, 1'b1);
    spi_end();
    check("t5 addr_hi", {10'h0, addr_hi}, 32'h4);
    check("t5 addr_lo", {30'h0, addr_lo}, 32'h0);
    check("t5 data", data, 32'h0002BBCC);

    // Disabled read, then the same read enabled
    enable = 1'b0;
    lc = load_cnt; sc = shift_cnt;
    read_tx(8'h03, 24'h002004, 4, 32'h000C6477);
    check("t6 disabled loads", 32'(load_cnt - lc), 32'd0);
    check("t6 disabled shifts", 32'(shift_cnt - sc), 32'd0);
    check("t6 disabled addr_hi", {10'h0, addr_hi}, 32'h4);
    check("t6 disabled data", data, 32'h0002BBCC);
    enable = 1'b1;
    exp_ac_q.push_back(24'h002004);
    exp_stb_q.push_back(32'h000C6477);
    read_tx(8'h03, 24'h002004, 4, 32'h000C6477);
    check("t6 addr_hi", {10'h0, addr_hi}, 32'h802);
    check("t6 addr_lo", {30'h0, addr_lo}, 32'h0);

    // FAST_READ: decoded only when the option is built in
    lc = load_cnt;
`ifdef SPI_SNIFF_FAST_READ_EN
    exp_ac_q.push_back(24'h000100);
    exp_stb_q.push_back(32'h44332211);
`endif
    spi_start();
    send_hdr(8'h0B, 24'h000100);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h11);
    spi_byte(8'h00, 8'h22);
    spi_byte(8'h00, 8'h33);
    spi_byte(8'h00, 8'h44);
    spi_end();
`ifdef SPI_SNIFF_FAST_READ_EN
    check("t7 fast loads", 32'(load_cnt - lc), 32'd5);
    check("t7 fast addr_hi", {10'h0, addr_hi}, 32'h41);
`else
    check("t7 fast ignored loads", 32'(load_cnt - lc), 32'd0);
    check("t7 fast ignored addr_hi", {10'h0, addr_hi}, 32'h802);
`endif

    check("pending addr_changed", 32'(exp_ac_q.size()), 32'd0);
    check("pending data_stb", 32'(exp_stb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
